// File: rtl/gate_op_arbiter_pkg.sv
// Shared types for the gate-op arbiter: opcode encoding, FSM state encoding
// and the opcode field width.
package gate_op_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_NOTB = 3'd7
    } gate_op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/gate_op_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters plus one result consumer
// (master side) and the gate-op arbiter (slave side).
interface gate_op_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int TAG_W   = 2
);
    logic [NUM_REQ-1:0]       req_valid_in;
    logic [NUM_REQ-1:0]       req_ready_out;
    logic [3*NUM_REQ-1:0]     req_op_in;
    logic [WIDTH*NUM_REQ-1:0] req_a_in;
    logic [WIDTH*NUM_REQ-1:0] req_b_in;
    logic                     res_valid_out;
    logic                     res_ready_in;
    logic [WIDTH-1:0]         res_data_out;
    logic [TAG_W-1:0]         res_tag_out;
    logic [15:0]              op_count_out;

    modport master (
        output req_valid_in, req_op_in, req_a_in, req_b_in, res_ready_in,
        input  req_ready_out, res_valid_out, res_data_out, res_tag_out, op_count_out
    );

    modport slave (
        input  req_valid_in, req_op_in, req_a_in, req_b_in, res_ready_in,
        output req_ready_out, res_valid_out, res_data_out, res_tag_out, op_count_out
    );
endinterface

// File: rtl/gate_op_arbiter_alu.sv
// Shared combinational bitwise gate unit: one of eight two-input bitwise
// functions across the full operand width.
module gate_alu
    import gate_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (gate_op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            OP_NOTB: y = ~b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one gate_alu among NUM_REQ requesters; returns a
// registered, requester-tagged result through a valid/ready handshake.
module gate_op_arbiter
    import gate_op_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int TAG_W   = 2
) (
    input logic              clk_in,
    input logic              rst_n_in,
    gate_op_arbiter_if.slave bus
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RESP = RESP;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]      count_q, count_d;

    logic             grantAny;
    logic [TAG_W-1:0] grantIdx;
    logic [OP_W-1:0]  selOp;
    logic [WIDTH-1:0] selA, selB, aluY;
    logic             slot, accept, consume;

    // Pass 0 only considers indices at or above rr_ptr; pass 1 covers the wrap.
    always_comb begin
        grantAny = 1'b0;
        grantIdx = '0;
        selOp    = '0;
        selA     = '0;
        selB     = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grantAny && bus.req_valid_in[i] &&
                    (pass == 1 || i >= int'(rr_ptr_q))) begin
                    grantAny = 1'b1;
                    grantIdx = TAG_W'(i);
                    selOp    = bus.req_op_in[OP_W*i +: OP_W];
                    selA     = bus.req_a_in[WIDTH*i +: WIDTH];
                    selB     = bus.req_b_in[WIDTH*i +: WIDTH];
                end
            end
        end
    end

    gate_alu #(.WIDTH(WIDTH)) u_alu (
        .op (selOp),
        .a  (selA),
        .b  (selB),
        .y  (aluY)
    );

    assign slot    = (state_q == ST_IDLE) || bus.res_ready_in;
    assign accept  = slot && grantAny;
    assign consume = (state_q == ST_RESP) && bus.res_ready_in;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        tag_d    = tag_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        if (accept) begin
            state_d  = ST_RESP;
            data_d   = aluY;
            tag_d    = grantIdx;
            rr_ptr_d = (grantIdx == TAG_W'(NUM_REQ - 1)) ? '0 : grantIdx + TAG_W'(1);
        end else if (consume) begin
            state_d = ST_IDLE;
        end
        if (consume && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            tag_q    <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Grant is combinational, so it is also masked while reset is held.
    assign bus.req_ready_out = (accept && rst_n_in) ? (NUM_REQ'(1) << grantIdx) : '0;
    assign bus.res_valid_out = (state_q == ST_RESP);
    assign bus.res_data_out  = data_q;
    assign bus.res_tag_out   = tag_q;
    assign bus.op_count_out  = count_q;

endmodule
